// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU request framer: gathers bytes between 3.5-character silences, runs a
// bit-serial CRC-16/MODBUS, filters on slave address and presents one decoded request.
module modbus_rtu_frame_rx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115_200,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  dev_addr,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        frame_valid,
    output logic [7:0]  fr_addr,
    output logic [7:0]  fr_func,
    output logic [15:0] fr_reg,
    output logic [15:0] fr_data,
    output logic        fr_bcast,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);
    localparam int unsigned T35_CYC  = (CLK_FREQ / BAUD_RATE) * 77 / 2;
    localparam int unsigned TMR_W    = $clog2(T35_CYC + 1);
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_MAX  = 15;
    localparam int unsigned PAY_LEN  = 6;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       pay_q [PAY_LEN];
    logic [15:0]      crc_q;
    logic [3:0]       bit_q;

    logic start_c, accept_c, finish_c, feed_c, crc_busy_c;
    logic addr_ok_c, len_ok_c, crc_ok_c, good_c, bad_c;

    assign crc_busy_c = (bit_q != 4'd0);
    assign feed_c     = accept_c && (cnt_q < CNT_W'(FRAME_LEN));
    assign addr_ok_c  = (pay_q[0] == dev_addr) || (pay_q[0] == 8'h00);
    assign len_ok_c   = (cnt_q == CNT_W'(FRAME_LEN));
    assign crc_ok_c   = (crc_q == 16'h0000);
    assign good_c     = finish_c && addr_ok_c && len_ok_c && crc_ok_c;
    assign bad_c      = finish_c && addr_ok_c && !(len_ok_c && crc_ok_c);

    // Silence of T35_CYC cycles after the last byte closes the frame; a byte
    // arriving during the check cycle opens the next frame immediately.
    always_comb begin
        state_d  = state_q;
        start_c  = 1'b0;
        accept_c = 1'b0;
        finish_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_done) begin
                    start_c = 1'b1;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (rx_done) begin
                    accept_c = 1'b1;
                end else if (tmr_q == TMR_W'(T35_CYC - 2)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!crc_busy_c) begin
                    finish_c = 1'b1;
                    if (rx_done) begin
                        start_c = 1'b1;
                        state_d = S_RECV;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Byte count, silence timer and payload capture; CRC bytes only feed the engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < PAY_LEN; i++) pay_q[i] <= 8'h00;
        end else begin
            if (start_c || accept_c) begin
                tmr_q <= '0;
            end else if (state_q == S_RECV) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end

            if (start_c) begin
                cnt_q    <= CNT_W'(1);
                pay_q[0] <= rx_data;
            end else if (finish_c) begin
                cnt_q <= '0;
            end else if (accept_c && (cnt_q != CNT_W'(CNT_MAX))) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            for (int i = 1; i < PAY_LEN; i++) begin
                if (accept_c && (cnt_q == CNT_W'(i))) pay_q[i] <= rx_data;
            end
        end
    end

    // Bit-serial CRC: XOR on byte load, then eight shift cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
            bit_q <= 4'd0;
        end else if (start_c) begin
            crc_q <= CRC_INIT ^ {8'h00, rx_data};
            bit_q <= 4'd8;
        end else if (finish_c) begin
            crc_q <= CRC_INIT;
        end else if (feed_c) begin
            crc_q <= crc_q ^ {8'h00, rx_data};
            bit_q <= 4'd8;
        end else if (crc_busy_c) begin
            crc_q <= crc_q[0] ? ((crc_q >> 1) ^ CRC_POLY) : (crc_q >> 1);
            bit_q <= bit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
            fr_addr     <= 8'h00;
            fr_func     <= 8'h00;
            fr_reg      <= 16'h0000;
            fr_data     <= 16'h0000;
            fr_bcast    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= good_c;
            frame_err   <= bad_c;
            busy        <= (state_d != S_IDLE);
            if (bad_c) begin
                err_code <= len_ok_c ? 2'd1 : 2'd2;
            end
            if (good_c) begin
                fr_addr  <= pay_q[0];
                fr_func  <= pay_q[1];
                fr_reg   <= {pay_q[2], pay_q[3]};
                fr_data  <= {pay_q[4], pay_q[5]};
                fr_bcast <= (pay_q[0] == 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Bench for modbus_rtu_frame_rx: frame-level model (byte timestamps, gap rule,
// bytewise CRC) with per-cycle comparison, directed cases and random frames.
module tb_modbus_rtu_frame_rx;
    localparam int unsigned CLK_FREQ  = 1_000_000;
    localparam int unsigned BAUD_RATE = 100_000;
    localparam int T35 = int'((CLK_FREQ / BAUD_RATE) * 77 / 2);

    typedef logic [7:0] barr_t [16];
    typedef struct {
        int         cyc;
        bit         err;
        logic [1:0] code;
        logic [7:0] addr;
        logic [7:0] func;
        logic [15:0] regw;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  dev_addr = 8'h01;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        frame_valid, fr_bcast, frame_err, busy;
    logic [7:0]  fr_addr, fr_func;
    logic [15:0] fr_reg, fr_data;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    ev_t evq[$];

    bit    in_frame = 0;
    int    first_rx = 0, last_rx = 0, bw_s = 0, bw_e = -1, fb_n = 0;
    barr_t fb;

    int          n_v = 0, n_e = 0, last_v_cyc = 0, last_rx_cyc = 0;
    logic [7:0]  prev_v_func = 8'h00, last_v_func = 8'h00;
    logic [1:0]  h_code = 2'd0;
    logic [48:0] h_fields = '0;

    always #5 clk = ~clk;

    modbus_rtu_frame_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .FRAME_LEN(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dev_addr   (dev_addr),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .frame_valid(frame_valid),
        .fr_addr    (fr_addr),
        .fr_func    (fr_func),
        .fr_reg     (fr_reg),
        .fr_data    (fr_data),
        .fr_bcast   (fr_bcast),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input barr_t d, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, d[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic barr_t mk(input logic [7:0] a, input logic [7:0] f,
                                 input logic [15:0] r, input logic [15:0] v);
        barr_t d;
        logic [15:0] c;
        d = '{default: 8'h00};
        d[0] = a; d[1] = f; d[2] = r[15:8]; d[3] = r[7:0]; d[4] = v[15:8]; d[5] = v[7:0];
        c = crc16(d, 6);
        d[6] = c[7:0];
        d[7] = c[15:8];
        return d;
    endfunction

    // A frame ends once T35-1 byte-free cycles follow its last byte.
    task automatic close_frame();
        ev_t ev;
        in_frame = 0;
        bw_s = first_rx + 1;
        bw_e = last_rx + T35;
        if (fb[0] == dev_addr || fb[0] == 8'h00) begin
            ev.cyc  = last_rx + T35 + 1;
            ev.addr = fb[0];
            ev.func = fb[1];
            ev.regw = {fb[2], fb[3]};
            ev.data = {fb[4], fb[5]};
            if (fb_n != 8) begin
                ev.err = 1; ev.code = 2'd2;
            end else if (crc16(fb, 6) != {fb[7], fb[6]}) begin
                ev.err = 1; ev.code = 2'd1;
            end else begin
                ev.err = 0; ev.code = 2'd0;
            end
            evq.push_back(ev);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                in_frame = 0; evq.delete(); bw_s = 0; bw_e = -1; fb_n = 0;
            end else if (rx_done) begin
                if (!in_frame) begin
                    in_frame = 1; first_rx = cyc - 1; fb_n = 0;
                end
                if (fb_n < 16) fb[fb_n] = rx_data;
                fb_n++;
                last_rx = cyc - 1;
            end else if (in_frame && (cyc - 1 - last_rx) == T35 - 1) begin
                close_frame();
            end
        end
    end

    initial begin
        ev_t ev;
        logic exp_v, exp_e, exp_busy;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                h_code = 2'd0;
                h_fields = '0;
                chk("reset_outputs", {frame_valid, frame_err, busy, err_code,
                                      fr_addr, fr_func, fr_reg, fr_data, fr_bcast}, 64'd0);
            end else begin
                exp_v = 0;
                exp_e = 0;
                while (evq.size() > 0 && evq[0].cyc < cyc) begin
                    ev = evq.pop_front();
                    chk("event_missed", 64'(cyc), 64'(ev.cyc));
                end
                if (evq.size() > 0 && evq[0].cyc == cyc) begin
                    ev = evq.pop_front();
                    if (ev.err) begin
                        exp_e = 1; h_code = ev.code;
                    end else begin
                        exp_v = 1;
                        h_fields = {ev.addr, ev.func, ev.regw, ev.data, ev.addr == 8'h00};
                    end
                end
                exp_busy = (in_frame && cyc >= first_rx + 1) || (cyc >= bw_s && cyc <= bw_e);
                chk("frame_valid", frame_valid, exp_v);
                chk("frame_err", frame_err, exp_e);
                chk("busy", busy, exp_busy);
                chk("err_code", err_code, h_code);
                chk("fields", {fr_addr, fr_func, fr_reg, fr_data, fr_bcast}, h_fields);
                if (frame_valid) begin
                    n_v++; last_v_cyc = cyc; prev_v_func = last_v_func; last_v_func = fr_func;
                end
                if (frame_err) n_e++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // gap = cycles from this byte's rx_done to the next one
    task automatic put(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_done = 1'b1; rx_data = b; last_rx_cyc = cyc;
        @(negedge clk);
        rx_done = 1'b0; rx_data = 8'($urandom);
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic send_frame(input barr_t d, input int n, input int end_gap);
        for (int i = 0; i < n; i++) put(d[i], (i == n - 1) ? end_gap : 100 + int'($urandom_range(0, 40)));
    endtask

    initial begin
        barr_t a, b;
        int v0, e0;
        #1 rst_n = 1'b0;
        idle(4);
        rst_n = 1'b1;
        idle(20);

        a = mk(8'h01, 8'h03, 16'h0000, 16'h0001);
        chk("crc_pin_read0", {a[7], a[6]}, 16'h0A84);

        // 1: good frame, latency and fields
        a = mk(8'h01, 8'h03, 16'h0001, 16'h0001);
        chk("crc_pin_read1", {a[6], a[7]}, 16'hD5CA);
        v0 = n_v; e0 = n_e;
        send_frame(a, 8, T35 + 20);
        chk("t1_valid_count", n_v - v0, 1);
        chk("t1_err_count", n_e - e0, 0);
        chk("t1_latency", last_v_cyc - last_rx_cyc, T35 + 1);
        chk("t1_fields", {fr_addr, fr_func, fr_reg, fr_data, fr_bcast}, {8'h01, 8'h03, 16'h0001, 16'h0001, 1'b0});

        // 2: CRC error keeps previous fields
        b = a; b[7] = 8'hCB;
        v0 = n_v; e0 = n_e;
        send_frame(b, 8, T35 + 20);
        chk("t2_err_count", n_e - e0, 1);
        chk("t2_err_code", err_code, 2'd1);
        chk("t2_valid_count", n_v - v0, 0);
        chk("t2_func_held", fr_func, 8'h03);

        // 3: foreign address is silent
        b = mk(8'hF0, 8'h03, 16'h0001, 16'h0001);
        v0 = n_v; e0 = n_e;
        send_frame(b, 8, T35 + 20);
        chk("t3_pulses", (n_v - v0) + (n_e - e0), 0);
        chk("t3_busy", busy, 1'b0);

        // 4: short and long frames
        b = mk(8'h01, 8'h04, 16'h0001, 16'h0004);
        b[8] = 8'h55;
        e0 = n_e;
        send_frame(b, 7, T35 + 20);
        send_frame(b, 9, T35 + 20);
        chk("t4_err_count", n_e - e0, 2);
        chk("t4_err_code", err_code, 2'd2);

        // 5: gap boundaries
        a = mk(8'h01, 8'h06, 16'h0001, 16'h0007);
        b = mk(8'h01, 8'h04, 16'h0002, 16'h0001);
        v0 = n_v; e0 = n_e;
        send_frame(a, 8, T35 / 2);
        send_frame(b, 8, T35 + 20);
        chk("t5a_pulses", (n_v - v0) + (n_e - e0), 1);
        chk("t5a_err_code", err_code, 2'd2);
        v0 = n_v; e0 = n_e;
        send_frame(a, 8, T35 - 1);
        send_frame(b, 8, T35 + 20);
        chk("t5b_merge_pulses", (n_v - v0) + (n_e - e0), 1);
        v0 = n_v;
        send_frame(a, 8, T35);
        send_frame(b, 8, T35 + 20);
        chk("t5c_check_cycle_valids", n_v - v0, 2);
        v0 = n_v;
        send_frame(a, 8, T35 + 1);
        send_frame(b, 8, T35 + 20);
        chk("t5d_valid_count", n_v - v0, 2);
        chk("t5d_first_func", prev_v_func, 8'h06);
        chk("t5d_second", {fr_addr, fr_func, fr_reg}, {8'h01, 8'h04, 16'h0002});

        // 6: reset mid-frame
        v0 = n_v; e0 = n_e;
        for (int i = 0; i < 4; i++) put(a[i], 110);
        @(negedge clk);
        rst_n = 1'b0;
        idle(3);
        #1;
        chk("t6_reset_outs", {frame_valid, frame_err, busy, err_code, fr_addr, fr_func, fr_reg, fr_data, fr_bcast}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(T35 + 20);
        chk("t6_no_pulse", (n_v - v0) + (n_e - e0), 0);
        send_frame(a, 8, T35 + 20);
        chk("t6_valid_count", n_v - v0, 1);
        chk("t6_fields", {fr_addr, fr_func, fr_reg, fr_data}, {8'h01, 8'h06, 16'h0001, 16'h0007});

        // 7: broadcast
        b = mk(8'h00, 8'h06, 16'h0005, 16'h1234);
        send_frame(b, 8, T35 + 20);
        chk("t7_bcast", {fr_bcast, fr_addr, fr_data}, {1'b1, 8'h00, 16'h1234});

        // random frames
        dev_addr = 8'($urandom_range(1, 247));
        idle(10);
        for (int f = 0; f < 25; f++) begin
            int sel, n, g, pos, bitn;
            logic [7:0] ad;
            barr_t d;
            sel = int'($urandom_range(0, 5));
            if (sel < 3) ad = dev_addr;
            else if (sel == 3) ad = 8'h00;
            else ad = dev_addr ^ 8'($urandom_range(1, 255));
            d = mk(ad, 8'($urandom_range(0, 255)), 16'($urandom), 16'($urandom));
            for (int k = 8; k < 16; k++) d[k] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                pos = int'($urandom_range(1, 7));
                bitn = int'($urandom_range(0, 7));
                d[pos] = d[pos] ^ 8'(1 << bitn);
            end
            sel = int'($urandom_range(0, 4));
            n = (sel == 0) ? 7 : (sel == 4) ? 9 : 8;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: g = T35 - 1;
                1: g = T35;
                2: g = T35 + 1;
                3: g = 150;
                default: g = T35 + int'($urandom_range(2, 300));
            endcase
            send_frame(d, n, g);
        end
        idle(T35 + 50);
        chk("events_drained", evq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modbus_rtu_frame_rx.md
Name: modbus_rtu_frame_rx

Overview:
Modbus RTU request framer. It sits between uart_byte_rx and the modbus_rtu_slave_top command decoder.
- Collects received bytes into a frame.
- Delimits frames by a 3.5-character silent interval.
- Checks the CRC-16/MODBUS with a bit-serial engine and filters by slave address.
- Presents one decoded 8-byte request (addr, func, reg, data) with a single-cycle valid strobe.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, UART baud rate; T35_CYC = (CLK_FREQ/BAUD_RATE)*77/2 (38.5 bit times, integer divide first; 16709 at defaults)
FRAME_LEN, 8, expected request length in bytes (addr, func, reg_hi, reg_lo, data_hi, data_lo, crc_lo, crc_hi)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
dev_addr  input  8  this slave's address, sampled when the frame is checked
rx_done  input  1  one-cycle pulse: rx_data holds a new byte
rx_data  input  8  received byte, valid while rx_done=1
frame_valid  output  1  one-cycle pulse: good frame presented on fr_* outputs
fr_addr  output  8  byte 0 of the accepted frame
fr_func  output  8  byte 1
fr_reg  output  16  {byte2, byte3}
fr_data  output  16  {byte4, byte5}
fr_bcast  output  1  1 when the accepted frame has fr_addr == 8'h00
frame_err  output  1  one-cycle pulse: addressed frame rejected
err_code  output  2  1 = CRC error, 2 = length error; held until the next frame_err
busy  output  1  1 from the first byte of a frame until the frame's check cycle completes

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, FSM to IDLE, byte count 0, silence timer 0, CRC register 16'hFFFF.
- FSM IDLE:
  - On rx_done, store the byte as byte 0, set count=1, clear the timer, start the CRC on the byte, then go to RECV.
- FSM RECV:
  - On each rx_done, store the byte at index count if count < FRAME_LEN.
  - Count increments and saturates at 15; the timer clears.
  - Otherwise the timer increments each cycle.
  - When the timer reaches T35_CYC-1, go to CHECK.
- FSM CHECK (1 cycle; if the CRC engine is still busy, stay in CHECK until it is idle):
  - count != FRAME_LEN → length error.
  - Else CRC residue != 16'h0000 → CRC error.
  - Else good.
  - Address filter: byte0 must equal dev_addr or 8'h00. A frame that fails the filter produces no pulse of any kind; this takes precedence over length and CRC errors. The filter is judged on byte 0 even for bad-length frames.
  - The next cycle pulses frame_valid (good) or frame_err with err_code (error).
  - The FSM returns to IDLE; the CRC register is reloaded with 16'hFFFF.
- Latency: frame_valid/frame_err is asserted exactly T35_CYC+1 cycles after the rx_done of the last byte, provided the CRC engine is idle.
- fr_* and fr_bcast update only with frame_valid and hold until the next frame_valid.
- CRC engine:
  - Algorithm: reflected polynomial 16'hA001, init 16'hFFFF.
  - On byte load: crc ^= {8'h00, byte}.
  - Then 8 cycles, one bit per cycle: crc = crc[0] ? (crc>>1)^16'hA001 : crc>>1.
  - All FRAME_LEN bytes, including the CRC bytes (low byte first), are fed, so a correct frame leaves residue 0. Bytes beyond FRAME_LEN are not fed.
- Boundaries:
  - rx_done in the same cycle the timer would reach T35_CYC-1: the byte belongs to the current frame and the timer clears.
  - rx_done during CHECK or the output cycle: the byte is buffered as byte 0 of the next frame, the timer starts, and no byte is lost.
  - rx_done while the CRC engine is busy cannot occur at legal rates (bytes arrive ≥ 10 bit times apart, and the engine is busy 8 cycles); no handling is required.
  - Overlong frame (>8 bytes): the first 8 bytes are kept, count saturates, and the frame is a length error.
  - Reset mid-frame: the partial frame is discarded and no pulse is generated.

Test Plan:
1. dev_addr=01; bytes 01 03 00 01 00 01 d5 ca → frame_valid 1 cycle, T35_CYC+1 after the last rx_done; fr_addr=01, fr_func=03, fr_reg=0001, fr_data=0001, fr_bcast=0.
2. dev_addr=01; bytes 01 03 00 01 00 01 d5 cb → frame_err with err_code=1; frame_valid stays 0; fr_* unchanged from the previous frame.
3. dev_addr=01; bytes f0 03 00 01 00 01 c0 eb → no frame_valid and no frame_err; busy returns to 0 after the check cycle.
4. dev_addr=01; 7-byte frame 01 04 00 01 00 04 a0, then 9-byte frame 01 04 00 01 00 04 a0 09 55 → frame_err with err_code=2 for each frame.
5. Frame 01 06 00 01 00 07 99 c8, then after a T35_CYC/2 gap frame 01 04 00 02 00 01 90 0a → frame_err err_code=2 with only 1 pulse in total (a half-length gap does not split the frame); repeat with a gap of exactly T35_CYC+1 cycles → two frame_valid pulses with fr_func=06 then 04, and the first byte of frame 2 is not lost.
6. Assert rst_n low after 4 bytes of frame 1 → all outputs 0; after release, a full valid frame yields frame_valid with correct fields.
